// File: rtl/image_loader.sv
// Pixel stream to parallel frame loader: zero-extends each pixel and assembles
// a full IMG_SIZE frame, holding it on m_image until the consumer takes it.
module image_loader #(
   parameter int IMG_SIZE = 784,
   parameter int PIX_W    = 8,
   parameter int DATA_W   = 32,
   parameter int CNT_W    = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [PIX_W-1:0]           s_data,
   input  logic                       s_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [IMG_SIZE*DATA_W-1:0] m_image,
   output logic [CNT_W-1:0]           pix_cnt,
   output logic                       err_short,
   output logic                       err_long,
   output logic [15:0]                frame_cnt
);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      DROP = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IMG_SIZE);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic               err_short_q, err_short_d;
   logic               err_long_q, err_long_d;
   // Only the pixel bits are stored; the upper word bits are always zero.
   logic [PIX_W-1:0]   pix_q [IMG_SIZE];
   logic [PIX_W-1:0]   pix_d [IMG_SIZE];
   logic               beat;

   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      frame_cnt_d = frame_cnt_q;
      err_short_d = 1'b0;
      err_long_d  = 1'b0;
      pix_d       = pix_q;
      beat        = s_valid && (state_q != FULL);

      case (state_q)
         FILL: begin
            if (beat) begin
               pix_d[pix_cnt_q] = s_data;
               if (pix_cnt_q == LAST_IDX) begin
                  pix_cnt_d = FULL_CNT;
                  state_d   = s_last ? FULL : DROP;
               end else if (s_last) begin
                  // Short frame: restart; stale words get overwritten next frame.
                  pix_cnt_d   = '0;
                  err_short_d = 1'b1;
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
         end
         DROP: begin
            if (beat && s_last) begin
               err_long_d = 1'b1;
               state_d    = FULL;
            end
         end
         FULL: begin
            if (m_ready) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               pix_cnt_d   = '0;
               state_d     = FILL;
            end
         end
         default: begin
            state_d   = FILL;
            pix_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         pix_cnt_q   <= '0;
         frame_cnt_q <= '0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         for (int k = 0; k < IMG_SIZE; k++) pix_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         pix_q       <= pix_d;
      end
   end

   for (genvar k = 0; k < IMG_SIZE; k++) begin : g_word
      assign m_image[k*DATA_W +: DATA_W] = {{(DATA_W-PIX_W){1'b0}}, pix_q[k]};
   end

   assign s_ready   = (state_q != FULL);
   assign m_valid   = (state_q == FULL);
   assign pix_cnt   = pix_cnt_q;
   assign frame_cnt = frame_cnt_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader against a frame-level queue model.
module tb_image_loader;
   localparam int IMG = 784;
   localparam int DW  = 32;

   typedef logic [7:0] frame_t [IMG];

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid, s_ready, s_last;
   logic [7:0]        s_data;
   logic              m_valid, m_ready;
   logic [IMG*DW-1:0] m_image;
   logic [9:0]        pix_cnt;
   logic              err_short, err_long;
   logic [15:0]       frame_cnt;

   int     total = 0;
   int     bad = 0;
   int     sent_cycles;
   int     exp_fc = 0;
   frame_t expq[$];

   image_loader dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_image(m_image),
      .pix_cnt(pix_cnt), .err_short(err_short), .err_long(err_long),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [IMG*DW-1:0] img_of(input frame_t f);
      logic [IMG*DW-1:0] r;
      for (int k = 0; k < IMG; k++) r[k*DW +: DW] = {24'h0, f[k]};
      return r;
   endfunction

   function automatic int first_diff(input logic [IMG*DW-1:0] a, input logic [IMG*DW-1:0] b);
      for (int k = 0; k < IMG; k++) if (a[k*DW +: DW] !== b[k*DW +: DW]) return k;
      return -1;
   endfunction

   // mode 0: k mod 256, mode 1: random, mode 2: all 0xFF
   task automatic send_frame(input int n, input int last_at, input int mode,
                             input bit rnd, input bit push);
      logic [7:0] cur [800];
      frame_t f;
      int i, guard;
      bit acc;
      for (int k = 0; k < n; k++)
         cur[k] = (mode == 0) ? 8'(k % 256) : (mode == 2) ? 8'hFF : 8'($urandom);
      if (push && n >= IMG && last_at == n - 1) begin
         for (int k = 0; k < IMG; k++) f[k] = cur[k];
         expq.push_back(f);
      end
      i = 0; guard = 0; sent_cycles = 0;
      while (i < n) begin
         s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_data  = cur[i];
         s_last  = (i == last_at);
         acc     = s_valid && s_ready;
         @(posedge clk); #1;
         sent_cycles++;
         if (acc) i++;
         guard++;
         if (guard > 20000) begin
            total++; bad++;
            $display("FAIL send_timeout sent=%0d wanted=%0d", i, n);
            break;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic do_reset();
      s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_fc = 0;
      expq.delete();
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      exp_fc++;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
      total++; if (pix_cnt !== 10'd0) begin bad++; $display("FAIL rst_pix_cnt got=%0d exp=0", pix_cnt); end
      total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
      total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {err_short, err_long}); end
      total++; if (m_image !== '0) begin bad++; $display("FAIL rst_image word=%0d nonzero", first_diff(m_image, '0)); end
   endtask

   task automatic test_basic();
      frame_t f;
      m_ready = 1'b1;
      send_frame(IMG, IMG - 1, 0, 1'b0, 1'b1);
      f = expq.pop_front();
      total++; if (sent_cycles != IMG) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", sent_cycles, IMG); end
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_m_valid got=%b exp=1", m_valid); end
      total++; if (m_image[300*DW +: DW] !== 32'h0000002C) begin bad++; $display("FAIL basic_w300 got=%h exp=0000002c", m_image[300*DW +: DW]); end
      total++; if (m_image[783*DW +: DW] !== 32'h0000000F) begin bad++; $display("FAIL basic_w783 got=%h exp=0000000f", m_image[783*DW +: DW]); end
      total++; if (m_image !== img_of(f)) begin bad++; $display("FAIL basic_image first bad word=%0d", first_diff(m_image, img_of(f))); end
      @(posedge clk); #1;
      exp_fc++;
      m_ready = 1'b0;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle m_valid=%b exp=0", m_valid); end
      total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL basic_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL basic_s_ready got=%b exp=1", s_ready); end
   endtask

   task automatic test_hold();
      frame_t f;
      logic [IMG*DW-1:0] snap;
      m_ready = 1'b0;
      send_frame(IMG, IMG - 1, 0, 1'b0, 1'b1);
      f = expq.pop_front();
      snap = img_of(f);
      for (int c = 0; c < 50; c++) begin
         s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'($urandom);
         total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL hold_m_valid cyc=%0d got=%b exp=1", c, m_valid); end
         total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL hold_s_ready cyc=%0d got=%b exp=0", c, s_ready); end
         total++; if (m_image !== snap) begin bad++; $display("FAIL hold_image cyc=%0d word=%0d", c, first_diff(m_image, snap)); end
         @(posedge clk); #1;
      end
      s_valid = 1'b0; s_last = 1'b0;
      total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL hold_fc_before got=%0d exp=%0d", frame_cnt, exp_fc); end
      handshake();
      total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL hold_fc_after got=%0d exp=%0d", frame_cnt, exp_fc); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL hold_s_ready_after got=%b exp=1", s_ready); end
   endtask

   task automatic test_short();
      frame_t f;
      m_ready = 1'b0;
      send_frame(100, 99, 1, 1'b1, 1'b1);
      total++; if (err_short !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", err_short); end
      total++; if (pix_cnt !== 10'd0) begin bad++; $display("FAIL short_pix_cnt got=%0d exp=0", pix_cnt); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL short_m_valid got=%b exp=0", m_valid); end
      @(posedge clk); #1;
      total++; if (err_short !== 1'b0) begin bad++; $display("FAIL short_err_pulse got=%b exp=0", err_short); end
      send_frame(IMG, IMG - 1, 1, 1'b1, 1'b1);
      f = expq.pop_front();
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL short_next_valid got=%b exp=1", m_valid); end
      total++; if (m_image !== img_of(f)) begin bad++; $display("FAIL short_next_image word=%0d", first_diff(m_image, img_of(f))); end
      handshake();
   endtask

   task automatic test_long();
      frame_t f;
      m_ready = 1'b0;
      send_frame(IMG - 1, -1, 1, 1'b0, 1'b0);
      total++; if (pix_cnt !== 10'd783) begin bad++; $display("FAIL long_mid_cnt got=%0d exp=783", pix_cnt); end
      do_reset();
      send_frame(790, 789, 1, 1'b1, 1'b1);
      f = expq.pop_front();
      total++; if (err_long !== 1'b1) begin bad++; $display("FAIL long_err got=%b exp=1", err_long); end
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL long_m_valid got=%b exp=1", m_valid); end
      total++; if (pix_cnt !== 10'd784) begin bad++; $display("FAIL long_pix_cnt got=%0d exp=784", pix_cnt); end
      total++; if (m_image !== img_of(f)) begin bad++; $display("FAIL long_image word=%0d", first_diff(m_image, img_of(f))); end
      @(posedge clk); #1;
      total++; if (err_long !== 1'b0) begin bad++; $display("FAIL long_err_pulse got=%b exp=0", err_long); end
      handshake();
      total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL long_fc got=%0d exp=%0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_zero_extend();
      m_ready = 1'b0;
      send_frame(IMG, IMG - 1, 2, 1'b0, 1'b1);
      void'(expq.pop_front());
      total++; if (m_image[0 +: DW] !== 32'h000000FF) begin bad++; $display("FAIL zext_w0 got=%h exp=000000ff", m_image[0 +: DW]); end
      total++; if (!($signed(m_image[783*DW +: DW]) > 0)) begin bad++; $display("FAIL zext_sign got=%h exp=positive", m_image[783*DW +: DW]); end
      handshake();
   endtask

   task automatic test_async_reset();
      frame_t f;
      m_ready = 1'b0;
      send_frame(400, -1, 1, 1'b0, 1'b0);
      total++; if (pix_cnt !== 10'd400) begin bad++; $display("FAIL ar_mid_cnt got=%0d exp=400", pix_cnt); end
      #2 rst_n = 1'b0;
      #1;
      exp_fc = 0;
      total++; if (pix_cnt !== 10'd0) begin bad++; $display("FAIL ar_pix_cnt got=%0d exp=0", pix_cnt); end
      total++; if (m_image !== '0) begin bad++; $display("FAIL ar_image word=%0d nonzero", first_diff(m_image, '0)); end
      total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL ar_frame_cnt got=%0d exp=0", frame_cnt); end
      @(posedge clk); #1 rst_n = 1'b1;
      send_frame(IMG, IMG - 1, 1, 1'b0, 1'b1);
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL ar_held_valid got=%b exp=1", m_valid); end
      #2 rst_n = 1'b0;
      #1;
      void'(expq.pop_back());
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL ar2_m_valid got=%b exp=0", m_valid); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ar2_s_ready got=%b exp=1", s_ready); end
      total++; if (m_image !== '0) begin bad++; $display("FAIL ar2_image word=%0d nonzero", first_diff(m_image, '0)); end
      @(posedge clk); #1 rst_n = 1'b1;
      send_frame(IMG, IMG - 1, 1, 1'b1, 1'b1);
      f = expq.pop_front();
      total++; if (m_image !== img_of(f)) begin bad++; $display("FAIL ar_next_image word=%0d", first_diff(m_image, img_of(f))); end
      handshake();
      total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL ar_fc got=%0d exp=%0d", frame_cnt, exp_fc); end
   endtask

   task automatic test_random();
      do_reset();
      fork
         begin
            for (int fr = 0; fr < 20; fr++) begin
               int len;
               len = ($urandom_range(0, 4) == 0) ? IMG + int'($urandom_range(1, 6)) : IMG;
               send_frame(len, len - 1, 1, 1'b1, 1'b1);
            end
         end
         begin
            int got, guard;
            logic [IMG*DW-1:0] exp_img;
            got = 0; guard = 0;
            while (got < 20 && guard < 60000) begin
               m_ready = 1'($urandom_range(0, 1));
               if (m_valid && m_ready) begin
                  total++;
                  if (expq.size() == 0) begin
                     bad++; $display("FAIL rand_unexpected_frame idx=%0d", got);
                  end else begin
                     exp_img = img_of(expq.pop_front());
                     if (m_image !== exp_img) begin
                        bad++; $display("FAIL rand_image frame=%0d word=%0d", got, first_diff(m_image, exp_img));
                     end
                  end
                  got++;
               end
               @(posedge clk); #1;
               guard++;
            end
            m_ready = 1'b0;
            if (got < 20) begin
               total++; bad++;
               $display("FAIL rand_timeout frames=%0d exp=20", got);
            end
         end
      join
      total++; if (frame_cnt !== 16'd20) begin bad++; $display("FAIL rand_frame_cnt got=%0d exp=20", frame_cnt); end
      total++; if (expq.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", expq.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_short();
      test_long();
      test_zero_extend();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/image_loader.md
# image_loader

Input stage of the MNIST inference datapath. Accepts one grayscale pixel per beat over a valid/ready stream and zero-extends each pixel to the 32-bit signed word width used by the first dense layer. Assembles a complete 784-pixel frame and presents it as one parallel vector to the layer-1 matrix multiplier, holding it until the consumer acknowledges. Replaces file-based image loading so frames can be streamed in back-to-back.

## Interface
Parameters:
- IMG_SIZE, 784, pixels per frame (28x28)
- PIX_W, 8, input pixel width (unsigned)
- DATA_W, 32, output word width (signed, two's complement)
- CNT_W, 10, pixel counter width; must satisfy 2^CNT_W > IMG_SIZE

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous reset, active low
- s_valid  in  1  pixel beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  PIX_W  pixel value, unsigned
- s_last  in  1  marks final beat of a frame
- m_valid  out  1  complete frame held on m_image
- m_ready  in  1  consumer takes the frame
- m_image  out  IMG_SIZE*DATA_W  frame; pixel k at bits [k*DATA_W +: DATA_W]
- pix_cnt  out  CNT_W  pixels stored in current frame
- err_short  out  1  one-cycle pulse: s_last before pixel IMG_SIZE-1
- err_long  out  1  one-cycle pulse: frame had more than IMG_SIZE beats
- frame_cnt  out  16  frames delivered, wraps 0xFFFF -> 0

## Operation
- Beat accepted when s_valid && s_ready at a rising edge; s_data/s_last ignored otherwise.
- Pixel stored as {(DATA_W-PIX_W){0}, s_data}; never negative.
- States:
  - FILL: s_ready=1, m_valid=0. Accepted beat written to word pix_cnt, pix_cnt+1.
    - Beat with pix_cnt<IMG_SIZE-1 and s_last=1: frame discarded, pix_cnt->0, err_short pulse, stay FILL. Words already written are not cleared but are overwritten by the next frame.
    - Beat with pix_cnt==IMG_SIZE-1 and s_last=1: -> FULL.
    - Beat with pix_cnt==IMG_SIZE-1 and s_last=0: -> DROP.
  - DROP: s_ready=1, m_valid=0; accepted beats discarded, m_image untouched. Beat with s_last=1: err_long pulse, -> FULL. Frame delivered is the first IMG_SIZE pixels.
  - FULL: s_ready=0, m_valid=1, m_image stable. On m_ready: frame_cnt+1, pix_cnt->0, -> FILL.
- m_valid, once high, stays high with m_image unchanged until m_ready sampled high.
- pix_cnt reads IMG_SIZE in FULL and DROP.
- Reset (rst_n low, any state, including mid-frame or with m_valid high): state FILL, s_ready=1 after release, m_valid=0, pix_cnt=0, frame_cnt=0, err_short=0, err_long=0, all m_image words 0. A partial frame is lost; a held frame is dropped without handshake.

## Timing
- s_ready, m_valid, err_* are registered (state-decoded); no combinational path from s_valid or m_ready to any output.
- Write latency: pixel accepted at edge N is visible on m_image after edge N.
- Frame latency: final beat accepted at edge N -> m_valid=1 from edge N.
- Handshake at edge M -> s_ready=1 from edge M; next beat accepted no earlier than edge M+1.
- Throughput: 1 pixel/cycle; IMG_SIZE+1 cycles per frame minimum when m_ready is held high (one FULL cycle).
- err_short/err_long high for exactly the cycle after the offending beat's edge.
- frame_cnt updates on the handshake edge.

## Test plan
- Reset, then stream pixels 0..783 as value k mod 256, s_valid=1 continuously, s_last on beat 783, m_ready=1 -> m_valid high for exactly 1 cycle 784 edges after first beat; word 300 = 0x0000002C; word 783 = 0x0000000F; frame_cnt=1.
- Same frame with m_ready=0 for 50 cycles -> m_valid and m_image stable throughout, s_ready=0, s_valid beats ignored; m_ready=1 -> frame_cnt increments, s_ready=1 next cycle.
- Frame with s_last on beat 99 -> err_short one cycle, pix_cnt=0, no m_valid; following correct frame delivered intact.
- Frame of 790 beats, s_last on beat 789 -> err_long one cycle, m_valid rises after beat 789, m_image holds beats 0..783 only.
- Pixel 0xFF -> output word 0x000000FF (zero-extended, positive); randomised s_valid/m_ready over 20 frames -> all frames match scoreboard, frame_cnt=20.
- rst_n low at beat 400 and again while m_valid=1 -> all outputs reset values immediately (asynchronous), m_image all zero; next full frame delivered correctly.
